clock_calendar_ctrl: RTL and testbench

Time-of-day and calendar sequencer for the digital clock. Consumes the 1 Hz square wave from the clock divider, converts each rising edge into a one-cycle second tick and advances a seconds/minutes/hours/day/month/year register set with full carry and leap-year handling. A mode/increment button FSM lets the user edit hour, minute, day, month and year, and the block feeds the display and formatting logic downstream.

---
 rtl/clock_calendar_ctrl.sv | 140 ++++++++++++++
 tb/tb_clock_calendar_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_calendar_ctrl.sv
// Time-of-day/calendar sequencer with button-driven field editing; counters update one cycle after a clk_1Hz rise.
// Buttons act on the edge they are sampled, day clamp one cycle later; no backpressure, all outputs registered.
module clock_calendar_ctrl #(
    parameter bit LEAP_EN = 1'b1
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       clk_1Hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year,
    output logic [2:0] set_field,
    output logic       sec_tick
);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        SET_HOUR  = 3'd1,
        SET_MIN   = 3'd2,
        SET_DAY   = 3'd3,
        SET_MONTH = 3'd4,
        SET_YEAR  = 3'd5
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       clk_1Hz_q;
    logic       tick;
    logic [4:0] dim;

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [6:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
            4'd2:                    days_in_month = (LEAP_EN && (y[1:0] == 2'b00)) ? 5'd29 : 5'd28;
            default:                 days_in_month = 5'd31;
        endcase
    endfunction

    assign dim       = days_in_month(month, year);
    assign set_field = state;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (btn_mode) begin
            case (state)
                RUN:       next_state = SET_HOUR;
                SET_HOUR:  next_state = SET_MIN;
                SET_MIN:   next_state = SET_DAY;
                SET_DAY:   next_state = SET_MONTH;
                SET_MONTH: next_state = SET_YEAR;
                default:   next_state = RUN;
            endcase
        end
    end

    // Registered edge detect: a rise seen on edge N is consumed on edge N+1.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            clk_1Hz_q <= 1'b1;
            tick      <= 1'b0;
        end else begin
            clk_1Hz_q <= clk_1Hz;
            tick      <= clk_1Hz & ~clk_1Hz_q;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            sec      <= 6'd0;
            min      <= 6'd0;
            hour     <= 5'd0;
            day      <= 5'd1;
            month    <= 4'd1;
            year     <= 7'd0;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            // Clamp sits first so any real day update on the same edge takes precedence.
            if (day > dim) begin
                day <= dim;
            end
            if ((state == RUN) && tick) begin
                sec_tick <= 1'b1;
                if (sec == 6'd59) begin
                    sec <= 6'd0;
                    if (min == 6'd59) begin
                        min <= 6'd0;
                        if (hour == 5'd23) begin
                            hour <= 5'd0;
                            if (day >= dim) begin
                                day <= 5'd1;
                                if (month == 4'd12) begin
                                    month <= 4'd1;
                                    year  <= (year == 7'd99) ? 7'd0 : year + 7'd1;
                                end else begin
                                    month <= month + 4'd1;
                                end
                            end else begin
                                day <= day + 5'd1;
                            end
                        end else begin
                            hour <= hour + 5'd1;
                        end
                    end else begin
                        min <= min + 6'd1;
                    end
                end else begin
                    sec <= sec + 6'd1;
                end
            end else if (btn_mode) begin
                if (state == SET_HOUR) begin
                    sec <= 6'd0;
                end
            end else if (btn_inc) begin
                case (state)
                    SET_HOUR:  hour  <= (hour == 5'd23)  ? 5'd0 : hour + 5'd1;
                    SET_MIN:   min   <= (min == 6'd59)   ? 6'd0 : min + 6'd1;
                    SET_DAY:   day   <= (day >= dim)     ? 5'd1 : day + 5'd1;
                    SET_MONTH: month <= (month == 4'd12) ? 4'd1 : month + 4'd1;
                    SET_YEAR:  year  <= (year == 7'd99)  ? 7'd0 : year + 7'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_calendar_ctrl.sv
// Scoreboard bench for clock_calendar_ctrl: stimulus queues expected snapshots and tick results, a monitor compares.
module tb_clock_calendar_ctrl;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic       clk_1Hz    = 1'b1;
    logic       btn_mode   = 1'b0;
    logic       btn_inc    = 1'b0;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [4:0] day;
    logic [3:0] month;
    logic [6:0] year;
    logic [2:0] set_field;
    logic       sec_tick;

    clock_calendar_ctrl #(.LEAP_EN(1'b1)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .clk_1Hz    (clk_1Hz),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .day        (day),
        .month      (month),
        .year       (year),
        .set_field  (set_field),
        .sec_tick   (sec_tick)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        string      name;
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hour;
        logic [4:0] day;
        logic [3:0] month;
        logic [6:0] year;
        logic [2:0] fs;
    } exp_t;

    exp_t snap_q[$];
    exp_t tick_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic sample_req = 1'b0;

    function automatic exp_t mk(input string n, input int s, input int mi, input int h,
                                input int d, input int mo, input int y, input int f);
        exp_t e;
        e.name  = n;
        e.sec   = 6'(s);
        e.min   = 6'(mi);
        e.hour  = 5'(h);
        e.day   = 5'(d);
        e.month = 4'(mo);
        e.year  = 7'(y);
        e.fs    = 3'(f);
        return e;
    endfunction

    task automatic compare(input exp_t e);
        n_tests++;
        if (sec !== e.sec || min !== e.min || hour !== e.hour || day !== e.day ||
            month !== e.month || year !== e.year || set_field !== e.fs) begin
            n_fail++;
            $display("FAIL %s: got %0d:%0d:%0d %0d/%0d/%0d fs=%0d, expected %0d:%0d:%0d %0d/%0d/%0d fs=%0d",
                     e.name, hour, min, sec, day, month, year, set_field,
                     e.hour, e.min, e.sec, e.day, e.month, e.year, e.fs);
        end
    endtask

    // Monitor: snapshot requests and every sec_tick pulse are matched against the queues.
    always @(negedge clk_100MHz) begin
        if (sample_req) begin
            if (snap_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL snapshot_queue: sample requested with nothing expected");
            end else begin
                compare(snap_q.pop_front());
            end
        end
        if (sec_tick) begin
            if (tick_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_tick: sec_tick=1 at sec=%0d fs=%0d, required no tick", sec, set_field);
            end else begin
                compare(tick_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            btn_inc = 1'b1;
            step();
            btn_inc = 1'b0;
        end
    endtask

    task automatic expect_now(input exp_t e);
        snap_q.push_back(e);
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
    endtask

    task automatic tick_exp(input exp_t e);
        tick_q.push_back(e);
        clk_1Hz = 1'b0;
        step();
        clk_1Hz = 1'b1;
        step();
        step();
    endtask

    task automatic tick_ignored();
        clk_1Hz = 1'b0;
        step();
        clk_1Hz = 1'b1;
        step();
        step();
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Date is set on a first pass so the day field never passes through a short month.
    task automatic preload(input int h, input int m, input int d, input int mo, input int y);
        reset_dut();
        press_mode(); press_mode(); press_mode();
        press_mode(); press_inc(mo - 1);
        press_mode(); press_inc(y);
        press_mode();
        press_mode(); press_inc(h);
        press_mode(); press_inc(m);
        press_mode(); press_inc(d - 1);
        press_mode(); press_mode(); press_mode();
        for (int i = 0; i < 59; i++) begin
            tick_exp(mk("preload_tick", i + 1, m, h, d, mo, y, 0));
        end
    endtask

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    endtask

    initial begin
        #1000000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        summary();
        $finish;
    end

    initial begin
        step();
        reset_dut();
        expect_now(mk("reset_values", 0, 0, 0, 1, 1, 0, 0));
        step(); step(); step();
        expect_now(mk("no_tick_high_at_release", 0, 0, 0, 1, 1, 0, 0));

        clk_1Hz = 1'b0;
        step();
        clk_1Hz = 1'b1;
        step();
        tick_q.push_back(mk("first_tick", 1, 0, 0, 1, 1, 0, 0));
        expect_now(mk("tick_latency_hold", 0, 0, 0, 1, 1, 0, 0));
        expect_now(mk("tick_applied", 1, 0, 0, 1, 1, 0, 0));
        step();

        preload(23, 59, 31, 12, 99);
        expect_now(mk("preload_end_of_century", 59, 59, 23, 31, 12, 99, 0));
        tick_exp(mk("rollover_century", 0, 0, 0, 1, 1, 0, 0));
        expect_now(mk("after_century", 0, 0, 0, 1, 1, 0, 0));

        preload(23, 59, 28, 2, 3);
        expect_now(mk("preload_feb_2003", 59, 59, 23, 28, 2, 3, 0));
        tick_exp(mk("rollover_feb_2003", 0, 0, 0, 1, 3, 3, 0));

        preload(23, 59, 28, 2, 4);
        expect_now(mk("preload_feb_2004", 59, 59, 23, 28, 2, 4, 0));
        tick_exp(mk("rollover_leap_2004", 0, 0, 0, 29, 2, 4, 0));

        reset_dut();
        tick_exp(mk("run_tick", 1, 0, 0, 1, 1, 0, 0));
        press_mode();
        for (int i = 0; i < 25; i++) begin
            press_inc(1);
            if (i % 5 == 0) tick_ignored();
        end
        expect_now(mk("hour_wrap_ticks_ignored", 1, 0, 1, 1, 1, 0, 1));

        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        expect_now(mk("mode_beats_inc", 0, 0, 1, 1, 1, 0, 2));

        press_mode();
        press_inc(30);
        expect_now(mk("day_set_31", 0, 0, 1, 31, 1, 0, 3));
        press_mode();
        press_inc(1);
        expect_now(mk("clamp_pending_month", 0, 0, 1, 31, 2, 0, 4));
        expect_now(mk("clamp_month_leap", 0, 0, 1, 29, 2, 0, 4));
        press_mode();
        press_inc(1);
        expect_now(mk("clamp_pending_year", 0, 0, 1, 29, 2, 1, 5));
        expect_now(mk("clamp_year_common", 0, 0, 1, 28, 2, 1, 5));

        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_now(mk("reset_mid_edit", 0, 0, 0, 1, 1, 0, 0));

        clk_1Hz = 1'b0;
        step();
        clk_1Hz = 1'b1;
        step();
        tick_q.push_back(mk("tick_with_mode_in_run", 1, 0, 0, 1, 1, 0, 1));
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        expect_now(mk("tick_then_advance", 1, 0, 0, 1, 1, 0, 1));

        press_mode(); press_mode(); press_mode(); press_mode();
        expect_now(mk("in_year_sec_cleared", 0, 0, 0, 1, 1, 0, 5));
        clk_1Hz = 1'b0;
        step();
        clk_1Hz = 1'b1;
        step();
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        expect_now(mk("tick_dropped_year_exit", 0, 0, 0, 1, 1, 0, 0));
        step(); step(); step();

        n_tests++;
        if (tick_q.size() != 0 || snap_q.size() != 0) begin
            n_fail++;
            $display("FAIL queues_drained: %0d ticks and %0d snapshots outstanding, required 0 and 0",
                     tick_q.size(), snap_q.size());
        end
        summary();
        $finish;
    end

endmodule
